// File: rtl/pong_pkg.sv
// Shared pong definitions: screen/paddle sizes, paddle bitmap type and quadrature helpers.
package pong_pkg;

   localparam int unsigned SCREEN_H     = 16;
   localparam int unsigned PADDLE_W_DEF = 3;

   typedef logic [15:0] paddle_t;

   typedef enum logic [1:0] {
      StepNone,
      StepUp,
      StepDown,
      StepErr
   } step_e;

   // Position of a pin pair along the 00->01->11->10 Gray cycle.
   function automatic logic [1:0] quad_phase(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   function automatic step_e quad_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
      logic [1:0] w_delta;
      w_delta = quad_phase(cur_ab) - quad_phase(prev_ab);
      case (w_delta)
         2'd1:    return StepUp;
         2'd3:    return StepDown;
         2'd2:    return StepErr;
         default: return StepNone;
      endcase
   endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchronizer for the encoder pins plus optional stability filter.
// The filter is built only when PADDLE_DEBOUNCE_EN is defined.
module enc_debounce
   import pong_pkg::*;
`ifdef PADDLE_DEBOUNCE_EN
#(
   parameter int unsigned DEBOUNCE = 4
)
`endif
(
   input  logic       game_clk,
`ifdef PADDLE_DEBOUNCE_EN
   input  logic       reset,
`endif
   input  logic       i_a,
   input  logic       i_b,
   output logic [1:0] o_s_ab,
   output logic [1:0] o_f_ab
);

   logic [1:0] r_meta;
   logic [1:0] r_sync;

   // Never reset, so the reset path can preload the current pin levels downstream.
   always_ff @(posedge game_clk) begin
      r_meta <= {i_a, i_b};
      r_sync <= r_meta;
   end

   assign o_s_ab = r_sync;

`ifdef PADDLE_DEBOUNCE_EN
   localparam logic [3:0] CntLast = 4'(DEBOUNCE - 1);

   logic [1:0] r_f_ab;
   logic [1:0] r_cand;
   logic [3:0] r_cnt;

   always_ff @(posedge game_clk) begin
      if (reset) begin
         r_f_ab <= r_sync;
         r_cand <= r_sync;
         r_cnt  <= '0;
      end else if (r_sync == r_f_ab) begin
         r_cnt  <= '0;
      end else if (r_cnt == 4'd0 || r_sync != r_cand) begin
         // First sample of a new candidate level.
         r_cand <= r_sync;
         r_cnt  <= 4'd1;
      end else if (r_cnt == CntLast) begin
         r_f_ab <= r_sync;
         r_cnt  <= '0;
      end else begin
         r_cnt  <= r_cnt + 4'd1;
      end
   end

   assign o_f_ab = r_f_ab;
`else
   assign o_f_ab = r_sync;
`endif

endmodule

// File: rtl/paddle_ctrl.sv
// Quadrature encoder to paddle bitmap: decoder, sub-step accumulator, saturating position.
// Define PADDLE_DEBOUNCE_EN to build the input stability filter.
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned HEIGHT           = SCREEN_H,
   parameter int unsigned PADDLE_W         = PADDLE_W_DEF,
   parameter int unsigned STEPS_PER_DETENT = 4,
   parameter int unsigned DEBOUNCE         = 4,
   parameter bit          DIR_INV          = 1'b0
) (
   input  logic              game_clk,
   input  logic              reset,
   input  logic              i_enc_a,
   input  logic              i_enc_b,
   output logic [HEIGHT-1:0] o_paddle,
   output logic [3:0]        o_pos,
   output logic              o_enc_err
);

   localparam int unsigned     PosMax = HEIGHT - PADDLE_W;
   localparam logic [3:0]      PosRst = 4'(PosMax / 2);
   localparam logic [3:0]      PosTop = 4'(PosMax);
   localparam logic signed [4:0] SubMax = 5'(STEPS_PER_DETENT - 1);
   localparam logic signed [4:0] SubMin = -SubMax;

   // Empty marker block: elaboration shows it when DEBOUNCE is out of range.
   if (DEBOUNCE < 2 || DEBOUNCE > 15) begin : g_debounce_out_of_range
   end

   logic [1:0]        w_s_ab;
   logic [1:0]        w_f_ab;
   logic [1:0]        r_prev_ab;
   logic [3:0]        r_pos;
   logic signed [4:0] r_sub;
   logic              r_enc_err;
   logic [3:0]        w_pos_nxt;
   logic signed [4:0] w_sub_nxt;
   logic              w_err_nxt;
   step_e             w_step;
   logic              w_fwd;

   enc_debounce
`ifdef PADDLE_DEBOUNCE_EN
   #(
      .DEBOUNCE (DEBOUNCE)
   )
`endif
   u_enc_debounce (
      .game_clk (game_clk),
`ifdef PADDLE_DEBOUNCE_EN
      .reset    (reset),
`endif
      .i_a      (i_enc_a),
      .i_b      (i_enc_b),
      .o_s_ab   (w_s_ab),
      .o_f_ab   (w_f_ab)
   );

   assign w_step = quad_step(r_prev_ab, w_f_ab);
   assign w_fwd  = (w_step == StepUp) ^ DIR_INV;

   always_comb begin
      w_pos_nxt = r_pos;
      w_sub_nxt = r_sub;
      w_err_nxt = 1'b0;
      unique case (w_step)
         StepErr: begin
            w_err_nxt = 1'b1;
            w_sub_nxt = '0;
         end
         StepUp, StepDown: begin
            if (w_fwd) begin
               if (r_sub == SubMax) begin
                  w_sub_nxt = '0;
                  if (r_pos != PosTop) w_pos_nxt = r_pos + 4'd1;
               end else begin
                  w_sub_nxt = r_sub + 5'sd1;
               end
            end else begin
               if (r_sub == SubMin) begin
                  w_sub_nxt = '0;
                  if (r_pos != 4'd0) w_pos_nxt = r_pos - 4'd1;
               end else begin
                  w_sub_nxt = r_sub - 5'sd1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge game_clk) begin
      if (reset) begin
         r_pos     <= PosRst;
         r_sub     <= '0;
         r_enc_err <= 1'b0;
         r_prev_ab <= w_s_ab;
      end else begin
         r_pos     <= w_pos_nxt;
         r_sub     <= w_sub_nxt;
         r_enc_err <= w_err_nxt;
         r_prev_ab <= w_f_ab;
      end
   end

   always_comb begin
      o_paddle = '0;
      for (int i = 0; i < int'(HEIGHT); i++) begin
         if (i >= int'(r_pos) && i < int'(r_pos) + int'(PADDLE_W)) o_paddle[i] = 1'b1;
      end
   end

   assign o_pos     = r_pos;
   assign o_enc_err = r_enc_err;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: directed scenarios plus a random encoder walk
// checked cycle by cycle against a detent-counting reference model.
module tb_paddle_ctrl;
   import pong_pkg::*;

   localparam int H    = SCREEN_H;
   localparam int PW   = PADDLE_W_DEF;
   localparam int S    = 4;
   localparam int DB   = 4;
   localparam bit INV  = 1'b0;
   localparam int MAXP = H - PW;
   localparam int RSTP = MAXP / 2;
`ifdef PADDLE_DEBOUNCE_EN
   localparam int LAT  = 2 + DB;
`else
   localparam int LAT  = 2;
`endif
   // Gray-cycle position of each pin pair, and the inverse.
   localparam int         PH    [4] = '{0, 1, 3, 2};
   localparam logic [1:0] AB_OF [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

   logic       game_clk = 1'b0;
   logic       reset;
   logic       enc_a;
   logic       enc_b;
   paddle_t    paddle;
   logic [3:0] pos;
   logic       enc_err;

   int         n_cmp  = 0;
   int         n_fail = 0;
   int         exp_pos;
   int         exp_sub;
   logic [1:0] cur_ab;
   string      test;

   paddle_ctrl #(
      .HEIGHT           (H),
      .PADDLE_W         (PW),
      .STEPS_PER_DETENT (S),
      .DEBOUNCE         (DB),
      .DIR_INV          (INV)
   ) dut (
      .game_clk  (game_clk),
      .reset     (reset),
      .i_enc_a   (enc_a),
      .i_enc_b   (enc_b),
      .o_paddle  (paddle),
      .o_pos     (pos),
      .o_enc_err (enc_err)
   );

   always #5 game_clk = ~game_clk;

   function automatic logic [31:0] bitmap(input int p);
      logic [31:0] m;
      m = ((32'd1 << PW) - 32'd1) << p;
      return m & 32'h0000_FFFF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s %s: observed %0h expected %0h", test, tag, obs, exp);
      end
   endtask

   task automatic check_now(input int p, input logic e);
      chk("pos", 32'(pos), 32'(p));
      chk("paddle", 32'(paddle), bitmap(p));
      chk("enc_err", 32'(enc_err), 32'(e));
   endtask

   task automatic tick();
      @(posedge game_clk);
      #1;
   endtask

   // Apply a new pin level, update the model, and check every cycle of the hold.
   task automatic drive(input logic [1:0] nab, input int hold);
      int   d;
      int   dir;
      int   old_pos;
      logic e_err;
      old_pos = exp_pos;
      e_err   = 1'b0;
      d = (PH[nab] - PH[cur_ab] + 4) % 4;
      if (d == 2) begin
         e_err   = 1'b1;
         exp_sub = 0;
      end else if (d != 0) begin
         dir = (d == 1) ? 1 : -1;
         if (INV) dir = -dir;
         exp_sub += dir;
         if (exp_sub == S || exp_sub == -S) begin
            exp_sub = 0;
            exp_pos += dir;
            if (exp_pos < 0) exp_pos = 0;
            if (exp_pos > MAXP) exp_pos = MAXP;
         end
      end
      cur_ab = nab;
      {enc_a, enc_b} = nab;
      for (int c = 1; c <= hold; c++) begin
         tick();
         check_now((c > LAT) ? exp_pos : old_pos, e_err && (c == LAT + 1));
      end
   endtask

   task automatic quarter(input int dir, input int hold);
      drive(AB_OF[(PH[cur_ab] + dir + 4) % 4], hold);
   endtask

   task automatic detent(input int dir, input int hold);
      for (int q = 0; q < S; q++) quarter(dir, hold);
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         tick();
         check_now(exp_pos, 1'b0);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (4) tick();
      exp_pos = RSTP;
      exp_sub = 0;
      check_now(RSTP, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      int hold;
      int r;
      reset  = 1'b1;
      enc_a  = 1'b0;
      enc_b  = 1'b0;
      cur_ab = 2'b00;

      test = "reset";
      do_reset();
      chk("pos_rst", 32'(pos), 32'd6);
      chk("paddle_rst", 32'(paddle), 32'h01C0);
      idle(20);

      test = "one_detent";
      detent(1, 10);
      chk("pos_after", 32'(pos), 32'd7);
      chk("paddle_after", 32'(paddle), 32'h0380);

      test = "sat_top";
      do_reset();
      for (int i = 0; i < 20; i++) detent(1, LAT + 2);
      chk("pos_top", 32'(pos), 32'd13);
      chk("paddle_top", 32'(paddle), 32'hE000);
      for (int i = 0; i < 3; i++) quarter(-1, LAT + 2);
      chk("pos_top_part", 32'(pos), 32'd13);
      quarter(-1, LAT + 2);
      chk("pos_top_back", 32'(pos), 32'd12);

      test = "sat_bot";
      do_reset();
      for (int i = 0; i < 20; i++) detent(-1, LAT + 2);
      chk("pos_bot", 32'(pos), 32'd0);
      chk("paddle_bot", 32'(paddle), 32'h0007);

      test = "half_back";
      do_reset();
      quarter(1, LAT + 3);
      quarter(1, LAT + 3);
      quarter(-1, LAT + 3);
      quarter(-1, LAT + 3);
      chk("pos_half", 32'(pos), 32'd6);

      test = "jump";
      do_reset();
      drive(cur_ab ^ 2'b11, LAT + 4);
      chk("pos_jump", 32'(pos), 32'd6);
      detent(1, LAT + 2);
      chk("pos_jump_detent", 32'(pos), 32'd7);

      test = "reset_mid";
      do_reset();
      quarter(1, LAT + 2);
      quarter(1, LAT + 2);
      do_reset();
      idle(20);
      chk("pos_rst_mid", 32'(pos), 32'd6);
      quarter(1, LAT + 2);
      quarter(1, LAT + 2);
      chk("pos_partial", 32'(pos), 32'd6);
      quarter(1, LAT + 2);
      quarter(1, LAT + 2);
      chk("pos_full", 32'(pos), 32'd7);

`ifdef PADDLE_DEBOUNCE_EN
      test = "glitch";
      do_reset();
      {enc_a, enc_b} = cur_ab ^ 2'b01;
      repeat (3) begin
         tick();
         check_now(exp_pos, 1'b0);
      end
      {enc_a, enc_b} = cur_ab;
      idle(12);
      detent(1, LAT + 2);
      chk("pos_glitch", 32'(pos), 32'd7);
`endif

      test = "random";
      do_reset();
      for (int i = 0; i < 300; i++) begin
         hold = LAT + 1 + int'($urandom_range(0, 3));
         r    = int'($urandom_range(0, 9));
         if (r == 0) drive(cur_ab ^ 2'b11, hold);
         else if (r <= 5) quarter(1, hold);
         else quarter(-1, hold);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Converts one player's quadrature rotary encoder into the 16-bit paddle bitmap consumed by the game core's `lpaddle`/`rpaddle` inputs. One instance per player, both in the `game_clk` (1000 Hz) domain. Contains the input synchronizer, an optional debounce filter, the quadrature decoder, and a saturating position counter. The paddle is a contiguous run of set bits.

## Interface
- `HEIGHT`, 16: screen rows; width of `paddle`.
- `PADDLE_W`, 3: paddle length in rows (1..HEIGHT).
- `STEPS_PER_DETENT`, 4: quadrature quarter-steps per one-row move (1..8).
- `DEBOUNCE`, 4: consecutive stable samples required by the filter (2..15); used only with the filter compiled in.
- `DIR_INV`, 0: 1 swaps the up and down directions.
- `game_clk`  in  1  game clock, 1000 Hz.
- `reset`  in  1  synchronous, active-high; clock `game_clk`.
- `enc_a`  in  1  encoder phase A, asynchronous.
- `enc_b`  in  1  encoder phase B, asynchronous.
- `paddle`  out  HEIGHT  bit i set when row i is covered by the paddle.
- `pos`  out  4  index of the paddle's lowest row, 0..HEIGHT-PADDLE_W.
- `enc_err`  out  1  one-cycle pulse on an illegal quadrature transition.

## Operation
- Synchronizer: two flops per phase give the synced pair `s_ab = {a,b}`.
- Filter (optional): `f_ab` takes a new `s_ab` only after `s_ab` has differed from `f_ab` with the same value for DEBOUNCE consecutive cycles. The count restarts if `s_ab` changes value or returns to `f_ab`. Without the filter, `f_ab = s_ab`.
- Decoder: `prev_ab` registers `f_ab`. Gray sequence 00→01→11→10→00 counts +1; the reverse counts −1. With DIR_INV=1 the signs swap. When both bits change, the decoder does not count, pulses `enc_err`, and clears `sub`.
- Sub-step accumulator `sub`: signed, range −(S−1)..S−1, where S = STEPS_PER_DETENT.
  - On +1 with `sub`=S−1: `pos`+1 and `sub`←0.
  - On −1 with `sub`=−(S−1): `pos`−1 and `sub`←0.
  - Otherwise `sub` moves by ±1.
  - A reversal mid-detent unwinds `sub` and does not move `pos`.
- Saturation: a move past 0 or past HEIGHT−PADDLE_W leaves `pos` unchanged and clears `sub`. There is no wrap-around.
- `paddle` is decoded combinationally from the `pos` register: bits `pos`..`pos`+PADDLE_W−1 are set and all others are clear.
- Reset values:
  - `pos` = (HEIGHT−PADDLE_W)/2, which is 6 for defaults, giving `paddle`=16'h01C0.
  - `sub`=0, `enc_err`=0, filter count 0.
  - `prev_ab` and `f_ab` are loaded from the current synchronizer output, so releasing reset never produces a spurious step.
- Reset mid-rotation discards any partial detent.

## Timing
- Edge k is the first `game_clk` edge at which a new pin level is sampled.
- Without the filter, `pos`/`paddle`/`enc_err` update at edge k+2.
- With the filter, they update at edge k+2+DEBOUNCE, provided the level is held.
- Rotation above one quarter-step per cycle (after filtering) shows up as illegal transitions. This is acceptable: human rotation is below 200 steps/s.
- `enc_err` is high for exactly one cycle per illegal transition.

## Configuration
- `PADDLE_DEBOUNCE_EN` defined: the filter is instantiated, with the latency given above. Glitches shorter than DEBOUNCE cycles are ignored.
- Not defined: `f_ab` is wired straight to `s_ab`, the DEBOUNCE parameter is ignored, and the filter logic is absent.

## Structure
- Shared package `pong_pkg` holds:
  - `SCREEN_H` = 16, which the instantiating level passes as HEIGHT.
  - `PADDLE_W_DEF` = 3.
  - the paddle bitmap typedef `paddle_t` (logic [15:0]).
- Sub-module `enc_debounce` contains the 2-bit synchronizer plus the filter, compiled per `PADDLE_DEBOUNCE_EN`. `paddle_ctrl` holds the decoder, accumulator, and bitmap decode.

## Test plan
- Reset with pins at 00 → `pos`=6, `paddle`=16'h01C0, `enc_err`=0, and no change for 20 cycles after reset is released.
- One full clockwise detent (00→01→11→10→00, each level held 10 cycles, defaults, no filter) → `pos`=7, `paddle`=16'h0380, with the change exactly 2 edges after 00 is sampled.
- 20 clockwise detents from reset → `pos` saturates at 13 (`paddle`=16'hE000), and `sub`=0 after each extra detent. 20 counter-clockwise detents → `pos`=0, `paddle`=16'h0007.
- Half detent forward (01,11) then back (01,00) → `pos` stays 6 and `enc_err` never asserts.
- 00→11 jump → `enc_err` high for exactly 1 cycle and `pos` unchanged. A following legal detent then moves `pos` by exactly 1.
- With `PADDLE_DEBOUNCE_EN`, DEBOUNCE=4:
  - a 3-cycle glitch 00→01→00 is ignored, with no `sub` change.
  - a held step changes `pos` at edge k+6 on the final quarter.
  - asserting `reset` mid-detent restores `pos`=6 with no step afterwards.
